wb_stage: RTL and testbench

Final pipeline stage, directly downstream of the memory stage.
- Registers the memory-stage result.
- Waits for and captures returning load data from the data cache.
- Performs byte/half/word extraction, sign extension and LWL/LWR merge.
- Drives the single register-file write port.
- Stalls upstream (WB_busy) while a load's data is still outstanding.

---
 rtl/wb_stage_pkg.sv | 24 ++
 rtl/wb_stage_load_align.sv | 45 ++++
 rtl/wb_stage.sv | 138 +++++++++++++
 tb/tb_wb_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: FSM encoding, load-type bundle
// and register-file constants.
package wb_stage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic lb;
        logic lbu;
        logic lh;
        logic lhu;
        logic lw;
        logic lwl;
        logic lwr;
    } load_type_t;

    localparam logic [4:0]   ZERO_REG = 5'd0;
    localparam int unsigned  WORD_W   = 32;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: byte/half extraction with sign/zero extension and the
// LWL/LWR merge with the old rt value. Purely combinational.
module load_align
    import wb_stage_pkg::*;
(
    input  load_type_t          ld_type,
    input  logic [1:0]          off,
    input  logic [WORD_W-1:0]   m,
    input  logic [WORD_W-1:0]   rt,
    output logic [WORD_W-1:0]   wdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = m[{off, 3'b000} +: 8];
        half_sel = off[1] ? m[31:16] : m[15:0];
        wdata    = m;
        if (ld_type.lb) begin
            wdata = {{24{byte_sel[7]}}, byte_sel};
        end else if (ld_type.lbu) begin
            wdata = {24'd0, byte_sel};
        end else if (ld_type.lh) begin
            wdata = {{16{half_sel[15]}}, half_sel};
        end else if (ld_type.lhu) begin
            wdata = {16'd0, half_sel};
        end else if (ld_type.lwl) begin
            case (off)
                2'd0:    wdata = {m[7:0],  rt[23:0]};
                2'd1:    wdata = {m[15:0], rt[15:0]};
                2'd2:    wdata = {m[23:0], rt[7:0]};
                default: wdata = m;
            endcase
        end else if (ld_type.lwr) begin
            case (off)
                2'd0:    wdata = m;
                2'd1:    wdata = {rt[31:24], m[31:8]};
                2'd2:    wdata = {rt[31:16], m[31:16]};
                default: wdata = {rt[31:8],  m[31:24]};
            endcase
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: holds the last pipeline slot, waits for load data from
// the cache, aligns it and drives the single register-file write port.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WB_stall,
    input  logic              MEM_goto_WB,
    input  logic [31:0]       MEM_pc,
    input  logic [31:0]       MEM_inst,
    input  logic [REG_AW-1:0] MEM_dest,
    input  logic [DATA_W-1:0] MEM_alu_result,
    input  logic [DATA_W-1:0] MEM_rt_value,
    input  logic              MEM_load,
    input  logic              MEM_LB,
    input  logic              MEM_LBU,
    input  logic              MEM_LH,
    input  logic              MEM_LHU,
    input  logic              MEM_LW,
    input  logic              MEM_LWL,
    input  logic              MEM_LWR,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_data_valid,
    output logic              WB_busy,
    output logic [3:0]        RF_wen,
    output logic [REG_AW-1:0] RF_waddr,
    output logic [DATA_W-1:0] RF_wdata,
    output logic              WB_valid,
    output logic [31:0]       WB_pc
);

    wb_state_e         state_q, state_d;
    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] rt_q, rt_d;
    logic              load_q, load_d;
    load_type_t        ld_type_q, ld_type_d;
    logic [DATA_W-1:0] buf_q, buf_d;

    logic              accept;
    logic              write_en;
    logic [DATA_W-1:0] aligned;
    logic              unused_inst;

    load_align u_align (
        .ld_type (ld_type_q),
        .off     (alu_q[1:0]),
        .m       (buf_q),
        .rt      (rt_q),
        .wdata   (aligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            inst_q    <= '0;
            dest_q    <= '0;
            alu_q     <= '0;
            rt_q      <= '0;
            load_q    <= 1'b0;
            ld_type_q <= '0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            dest_q    <= dest_d;
            alu_q     <= alu_d;
            rt_q      <= rt_d;
            load_q    <= load_d;
            ld_type_q <= ld_type_d;
            buf_q     <= buf_d;
        end
    end

    // Accept can only happen in IDLE, so the WAIT/WRITE branch never overlaps it.
    always_comb begin
        accept    = !WB_stall && !WB_busy;
        state_d   = state_q;
        valid_d   = valid_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        dest_d    = dest_q;
        alu_d     = alu_q;
        rt_d      = rt_q;
        load_d    = load_q;
        ld_type_d = ld_type_q;
        buf_d     = buf_q;
        if (accept) begin
            valid_d   = MEM_goto_WB;
            pc_d      = MEM_goto_WB ? MEM_pc         : '0;
            inst_d    = MEM_goto_WB ? MEM_inst       : '0;
            dest_d    = MEM_goto_WB ? MEM_dest       : '0;
            alu_d     = MEM_goto_WB ? MEM_alu_result : '0;
            rt_d      = MEM_goto_WB ? MEM_rt_value   : '0;
            load_d    = MEM_goto_WB && MEM_load;
            ld_type_d = MEM_goto_WB
                      ? {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LWL, MEM_LWR}
                      : '0;
            state_d   = (MEM_goto_WB && MEM_load) ? WAIT : IDLE;
        end else if (!WB_stall) begin
            case (state_q)
                WAIT: begin
                    if (ld_data_valid) begin
                        buf_d   = ld_data;
                        state_d = WRITE;
                    end
                end
                WRITE:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        WB_busy  = (state_q == WAIT) || (state_q == WRITE);
        write_en = !WB_stall && valid_q && (dest_q != ZERO_REG)
                 && (((state_q == IDLE) && !load_q) || (state_q == WRITE));
        RF_wen   = write_en ? 4'hF : 4'h0;
        RF_waddr = dest_q;
        RF_wdata = (state_q == WRITE) ? aligned : alu_q;
        WB_valid = valid_q;
        WB_pc    = pc_q;
    end

    assign unused_inst = ^inst_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a transaction-level
// reference of the write-back rules.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        WB_stall;
    logic        MEM_goto_WB;
    logic [31:0] MEM_pc;
    logic [31:0] MEM_inst;
    logic [4:0]  MEM_dest;
    logic [31:0] MEM_alu_result;
    logic [31:0] MEM_rt_value;
    logic        MEM_load;
    logic        MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LWL, MEM_LWR;
    logic [31:0] ld_data;
    logic        ld_data_valid;
    logic        WB_busy;
    logic [3:0]  RF_wen;
    logic [4:0]  RF_waddr;
    logic [31:0] RF_wdata;
    logic        WB_valid;
    logic [31:0] WB_pc;

    int errors = 0;
    int checks = 0;

    wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .WB_stall       (WB_stall),
        .MEM_goto_WB    (MEM_goto_WB),
        .MEM_pc         (MEM_pc),
        .MEM_inst       (MEM_inst),
        .MEM_dest       (MEM_dest),
        .MEM_alu_result (MEM_alu_result),
        .MEM_rt_value   (MEM_rt_value),
        .MEM_load       (MEM_load),
        .MEM_LB         (MEM_LB),
        .MEM_LBU        (MEM_LBU),
        .MEM_LH         (MEM_LH),
        .MEM_LHU        (MEM_LHU),
        .MEM_LW         (MEM_LW),
        .MEM_LWL        (MEM_LWL),
        .MEM_LWR        (MEM_LWR),
        .ld_data        (ld_data),
        .ld_data_valid  (ld_data_valid),
        .WB_busy        (WB_busy),
        .RF_wen         (RF_wen),
        .RF_waddr       (RF_waddr),
        .RF_wdata       (RF_wdata),
        .WB_valid       (WB_valid),
        .WB_pc          (WB_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ty: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR
    function automatic logic [31:0] ref_align(input int ty, input logic [31:0] addr,
                                              input logic [31:0] m, input logic [31:0] rt);
        int          off;
        int          sh;
        logic [31:0] b;
        logic [31:0] h;
        off = int'(addr & 32'd3);
        b   = (m >> (8 * off)) & 32'hFF;
        h   = (m >> (16 * (off / 2))) & 32'hFFFF;
        case (ty)
            0: return (b > 32'h7F) ? (b | 32'hFFFF_FF00) : b;
            1: return b;
            2: return (h > 32'h7FFF) ? (h | 32'hFFFF_0000) : h;
            3: return h;
            5: begin
                sh = 8 * (3 - off);
                return (m << sh) | (rt & ((32'h1 << sh) - 32'h1));
            end
            6: begin
                sh = 8 * off;
                return (m >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
            end
            default: return m;
        endcase
    endfunction

    task automatic drive_quiet();
        MEM_goto_WB    = 1'b0;
        MEM_load       = 1'b0;
        {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LWL, MEM_LWR} = 7'd0;
        MEM_pc         = $urandom;
        MEM_inst       = $urandom;
        MEM_dest       = 5'($urandom);
        MEM_alu_result = $urandom;
        MEM_rt_value   = $urandom;
    endtask

    task automatic do_nonload(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] alu);
        @(posedge clk); #1;
        drive_quiet();
        MEM_goto_WB    = 1'b1;
        MEM_pc         = pc;
        MEM_dest       = dest;
        MEM_alu_result = alu;
        @(posedge clk); #1;
        drive_quiet();
        @(negedge clk);
        check("alu_wen",   32'(RF_wen),   (dest != 5'd0) ? 32'hF : 32'h0);
        check("alu_waddr", 32'(RF_waddr), 32'(dest));
        check("alu_wdata", RF_wdata,      alu);
        check("alu_busy",  32'(WB_busy),  32'h0);
        check("alu_valid", 32'(WB_valid), 32'h1);
        check("alu_pc",    WB_pc,         pc);
        @(posedge clk); #1;
        @(negedge clk);
        check("bubble_valid", 32'(WB_valid), 32'h0);
        check("bubble_wen",   32'(RF_wen),   32'h0);
        check("bubble_pc",    WB_pc,         32'h0);
    endtask

    // Data pulse arrives in the (k+1)-th cycle after capture; the WRITE cycle
    // is then held by s stall cycles; junk adds an ignored pulse during WRITE.
    task automatic do_load(input int ty, input logic [31:0] pc, input logic [4:0] dest,
                           input logic [31:0] addr, input logic [31:0] rt, input logic [31:0] data,
                           input int k, input int s, input bit junk);
        logic [31:0] exp;
        logic [6:0]  onehot;
        int          busy_cnt;
        int          writes;
        int          wcyc;
        bit          done;
        exp      = ref_align(ty, addr, data, rt);
        onehot   = 7'b1000000 >> ty;
        busy_cnt = 0;
        writes   = 0;
        wcyc     = 0;
        done     = 1'b0;
        @(posedge clk); #1;
        drive_quiet();
        MEM_goto_WB    = 1'b1;
        MEM_load       = 1'b1;
        {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LWL, MEM_LWR} = onehot;
        MEM_pc         = pc;
        MEM_dest       = dest;
        MEM_alu_result = addr;
        MEM_rt_value   = rt;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge clk); #1;
            drive_quiet();
            ld_data_valid = (c == k + 1) || (junk && (c == k + 2 + s));
            ld_data       = (c == k + 1) ? data : $urandom;
            WB_stall      = (s > 0) && (c >= k + 2) && (c <= k + 1 + s);
            @(negedge clk);
            if (WB_busy) busy_cnt++;
            else done = 1'b1;
            if (RF_wen != 4'h0) begin
                writes++;
                wcyc = c;
                check("ld_wen",   32'(RF_wen),   32'hF);
                check("ld_waddr", 32'(RF_waddr), 32'(dest));
                check("ld_wdata", RF_wdata,      exp);
            end
        end
        ld_data_valid = 1'b0;
        WB_stall      = 1'b0;
        check("ld_done",   32'(done),     32'h1);
        check("ld_busy",   32'(busy_cnt), 32'(k + 2 + s));
        check("ld_writes", 32'(writes),   (dest != 5'd0) ? 32'h1 : 32'h0);
        if (dest != 5'd0) check("ld_wcyc", 32'(wcyc), 32'(k + 2 + s));
    endtask

    task automatic reset_mid_wait();
        @(posedge clk); #1;
        drive_quiet();
        MEM_goto_WB    = 1'b1;
        MEM_load       = 1'b1;
        MEM_LW         = 1'b1;
        MEM_pc         = 32'h0000_4000;
        MEM_dest       = 5'd7;
        MEM_alu_result = 32'h0000_0100;
        @(posedge clk); #1;
        drive_quiet();
        reset = 1'b1;
        @(negedge clk);
        check("rst_pre_busy", 32'(WB_busy), 32'h1);
        @(posedge clk); #1;
        reset         = 1'b0;
        ld_data_valid = 1'b1;
        ld_data       = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_busy",  32'(WB_busy),  32'h0);
        check("rst_valid", 32'(WB_valid), 32'h0);
        @(posedge clk); #1;
        ld_data_valid = 1'b0;
        @(negedge clk);
        check("rst_post_wen",   32'(RF_wen),   32'h0);
        check("rst_post_busy",  32'(WB_busy),  32'h0);
        check("rst_post_valid", 32'(WB_valid), 32'h0);
        check("rst_post_wdata", RF_wdata,      32'h0);
    endtask

    initial begin
        reset         = 1'b1;
        WB_stall      = 1'b0;
        ld_data       = '0;
        ld_data_valid = 1'b0;
        drive_quiet();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_valid", 32'(WB_valid), 32'h0);
        check("reset_pc",    WB_pc,         32'h0);
        check("reset_wen",   32'(RF_wen),   32'h0);
        check("reset_waddr", 32'(RF_waddr), 32'h0);
        check("reset_wdata", RF_wdata,      32'h0);
        check("reset_busy",  32'(WB_busy),  32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        do_nonload(32'h0000_1000, 5'd5, 32'h1234_5678);
        do_load(0, 32'h0000_1004, 5'd3, 32'h0000_0103, 32'h0, 32'h80FF_1234, 3, 0, 1'b0);
        do_load(1, 32'h0000_1008, 5'd4, 32'h0000_0103, 32'h0, 32'h80FF_1234, 3, 0, 1'b0);
        do_load(5, 32'h0000_100C, 5'd6, 32'h0000_0201, 32'h1122_3344, 32'hAABB_CCDD, 0, 0, 1'b0);
        do_load(6, 32'h0000_1010, 5'd6, 32'h0000_0202, 32'h1122_3344, 32'hAABB_CCDD, 1, 0, 1'b1);
        do_load(4, 32'h0000_1014, 5'd0, 32'h0000_0300, 32'h0, 32'h5555_AAAA, 2, 0, 1'b0);
        do_nonload(32'h0000_1018, 5'd0, 32'hCAFE_F00D);
        reset_mid_wait();
        do_load(4, 32'h0000_101C, 5'd9, 32'h0000_0400, 32'h0, 32'h0BAD_F00D, 1, 2, 1'b0);

        for (int n = 0; n < 150; n++) begin
            int          r;
            logic [4:0]  d;
            r = int'($urandom_range(0, 7));
            d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if (r == 7)
                do_nonload($urandom, d, $urandom);
            else
                do_load(r, $urandom, d, $urandom, $urandom, $urandom,
                        int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                        1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
